// File: rtl/demux.sv
// Two-way demultiplexer: routes each word by bit 7 through a 2-entry
// in-order FIFO with head-of-line blocking and registered outputs.
module demux (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in_c,
    input  logic       valid_in_c,
    input  logic       pause_0_c,
    input  logic       pause_1_c,
    output logic [7:0] data_out_0_c,
    output logic       valid_out_0_c,
    output logic [7:0] data_out_1_c,
    output logic       valid_out_1_c,
    output logic       pause_out_c,
    output logic       overflow_c
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t     state_q;
    logic [7:0] buf0_q;
    logic [7:0] buf1_q;
    logic [7:0] d0_q;
    logic [7:0] d1_q;
    logic       v0_q;
    logic       v1_q;
    logic       pause_q;
    logic       ovf_q;

    logic       push;
    logic       have_head;
    logic [7:0] head;
    logic       head_paused;
    logic       pop;

    // An empty FIFO lets the incoming word act as the head (bypass).
    always_comb begin
        push        = valid_in_c & ~reset;
        have_head   = (state_q != EMPTY) | push;
        head        = (state_q == EMPTY) ? data_in_c : buf0_q;
        head_paused = head[7] ? pause_1_c : pause_0_c;
        pop         = have_head & ~head_paused;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            buf0_q  <= 8'h00;
            buf1_q  <= 8'h00;
            d0_q    <= 8'h00;
            d1_q    <= 8'h00;
            v0_q    <= 1'b0;
            v1_q    <= 1'b0;
            pause_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            d0_q <= (pop & ~head[7]) ? head : 8'h00;
            v0_q <= pop & ~head[7];
            d1_q <= (pop & head[7]) ? head : 8'h00;
            v1_q <= pop & head[7];
            unique case (state_q)
                EMPTY: begin
                    if (push & ~pop) begin
                        buf0_q  <= data_in_c;
                        state_q <= ONE;
                        pause_q <= 1'b1;
                    end else begin
                        pause_q <= 1'b0;
                    end
                end
                ONE: begin
                    pause_q <= 1'b1;
                    if (push & ~pop) begin
                        buf1_q  <= data_in_c;
                        state_q <= FULL;
                    end else if (~push & pop) begin
                        state_q <= EMPTY;
                        pause_q <= 1'b0;
                    end else if (push & pop) begin
                        buf0_q <= data_in_c;
                    end
                end
                FULL: begin
                    pause_q <= 1'b1;
                    if (pop) begin
                        buf0_q <= buf1_q;
                        if (push) begin
                            buf1_q <= data_in_c;
                        end else begin
                            state_q <= ONE;
                        end
                    end else if (push) begin
                        ovf_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                    pause_q <= 1'b0;
                end
            endcase
        end
    end

    assign data_out_0_c  = d0_q;
    assign valid_out_0_c = v0_q;
    assign data_out_1_c  = d1_q;
    assign valid_out_1_c = v1_q;
    assign pause_out_c   = pause_q;
    assign overflow_c    = ovf_q;

endmodule

// File: tb/tb_demux.sv
// Randomized and directed bench for demux against a queue-based
// reference model of the routing FIFO.
module tb_demux;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in_c;
    logic       valid_in_c;
    logic       pause_0_c;
    logic       pause_1_c;
    logic [7:0] data_out_0_c;
    logic       valid_out_0_c;
    logic [7:0] data_out_1_c;
    logic       valid_out_1_c;
    logic       pause_out_c;
    logic       overflow_c;

    int checks = 0;
    int errors = 0;

    logic [7:0] mq[$];
    logic       m_ovf = 1'b0;

    demux dut (
        .clk          (clk),
        .reset        (reset),
        .data_in_c    (data_in_c),
        .valid_in_c   (valid_in_c),
        .pause_0_c    (pause_0_c),
        .pause_1_c    (pause_1_c),
        .data_out_0_c (data_out_0_c),
        .valid_out_0_c(valid_out_0_c),
        .data_out_1_c (data_out_1_c),
        .valid_out_1_c(valid_out_1_c),
        .pause_out_c  (pause_out_c),
        .overflow_c   (overflow_c)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance model, then compare registered outputs.
    task automatic step(input bit v, input logic [7:0] d,
                        input bit p0, input bit p1, input bit r);
        logic [7:0] tmp[$];
        logic [7:0] hd;
        logic [7:0] e_d0, e_d1;
        bit         e_v0, e_v1, e_po, pop;
        reset      = r;
        valid_in_c = v;
        data_in_c  = d;
        pause_0_c  = p0;
        pause_1_c  = p1;
        e_d0 = 8'h00; e_d1 = 8'h00;
        e_v0 = 1'b0;  e_v1 = 1'b0;
        if (r) begin
            mq.delete();
            m_ovf = 1'b0;
            e_po  = 1'b0;
        end else begin
            tmp = mq;
            if (v) tmp.push_back(d);
            pop = 1'b0;
            if (tmp.size() > 0) begin
                hd  = tmp[0];
                pop = hd[7] ? !p1 : !p0;
                if (pop) begin
                    if (hd[7]) begin e_d1 = hd; e_v1 = 1'b1; end
                    else       begin e_d0 = hd; e_v0 = 1'b1; end
                    void'(tmp.pop_front());
                end
            end
            if (tmp.size() > 2) begin
                void'(tmp.pop_back());
                m_ovf = 1'b1;
            end
            e_po = tmp.size() >= 1;
            mq   = tmp;
        end
        @(posedge clk);
        #1;
        check("data0", data_out_0_c, e_d0);
        check("valid0", {7'd0, valid_out_0_c}, {7'd0, e_v0});
        check("data1", data_out_1_c, e_d1);
        check("valid1", {7'd0, valid_out_1_c}, {7'd0, e_v1});
        check("pause_out", {7'd0, pause_out_c}, {7'd0, e_po});
        check("overflow", {7'd0, overflow_c}, {7'd0, m_ovf});
    endtask

    task automatic idle(input int n, input bit p0, input bit p1);
        for (int i = 0; i < n; i++) step(0, 8'h00, p0, p1, 0);
    endtask

    initial begin
        step(0, 8'h00, 0, 0, 1);
        step(1, 8'h99, 0, 0, 1);

        // straight routing
        step(1, 8'h05, 0, 0, 0);
        check("route_p0", data_out_0_c, 8'h05);
        step(1, 8'h85, 0, 0, 0);
        check("route_p1", data_out_1_c, 8'h85);
        idle(2, 0, 0);

        // pause and buffer
        step(1, 8'h11, 1, 0, 0);
        check("pause_asserted", {7'd0, pause_out_c}, 8'h01);
        step(1, 8'h12, 1, 0, 0);
        idle(2, 1, 0);
        step(0, 8'h00, 0, 0, 0);
        check("buf_first", data_out_0_c, 8'h11);
        step(0, 8'h00, 0, 0, 0);
        check("buf_second", data_out_0_c, 8'h12);
        idle(2, 0, 0);

        // head-of-line blocking
        step(1, 8'h20, 1, 0, 0);
        step(1, 8'hA0, 1, 0, 0);
        idle(2, 1, 0);
        check("hol_blocked", {7'd0, valid_out_1_c}, 8'h00);
        idle(3, 0, 0);

        // overflow
        step(1, 8'h81, 0, 1, 0);
        step(1, 8'h82, 0, 1, 0);
        step(1, 8'h83, 0, 1, 0);
        check("ovf_set", {7'd0, overflow_c}, 8'h01);
        idle(2, 0, 1);
        idle(4, 0, 0);
        check("ovf_sticky", {7'd0, overflow_c}, 8'h01);
        step(0, 8'h00, 0, 0, 1);

        // full with simultaneous push and pop
        step(1, 8'h01, 1, 0, 0);
        step(1, 8'h02, 1, 0, 0);
        step(1, 8'h03, 0, 0, 0);
        check("fpp_first", data_out_0_c, 8'h01);
        idle(3, 0, 0);
        check("fpp_no_ovf", {7'd0, overflow_c}, 8'h00);

        // reset mid-operation
        step(1, 8'h01, 1, 0, 0);
        step(1, 8'h02, 1, 0, 0);
        step(0, 8'h00, 1, 0, 1);
        step(1, 8'h07, 0, 0, 0);
        check("post_reset", data_out_0_c, 8'h07);
        idle(3, 0, 0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0,
                 8'($urandom),
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 59) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
